// File: rtl/tx_piso_serializer.sv
// tx_piso_serializer: 10-bit parallel-in/serial-out serializer for the SerDes TX path.
// Accepts symbols over a valid/ready handshake into a single-entry holding buffer
// and shifts them out LSB-first, one bit per Bit_Rate cycle. Empty symbol slots
// are filled with IDLE_SYMBOL so the line never stalls.
//
// Ports:
//   Bit_Rate    in   serial bit clock (only clock)
//   Rst         in   asynchronous active-low reset
//   Data_In     in   encoded symbol, bit0 transmitted first
//   Data_Valid  in   Data_In is valid
//   Data_Ready  out  combinational accept enable (from registers only)
//   TX_Out      out  serial line bit
//   Sym_Start   out  high while TX_Out carries bit0 of a symbol
//   Idle_Out    out  high for all bits of an inserted idle symbol
//   Underflow   out  one-cycle pulse when an idle symbol follows a data symbol
module tx_piso_serializer #(
    parameter int unsigned             DATA_WIDTH  = 10,
    parameter logic [DATA_WIDTH-1:0]   IDLE_SYMBOL = 10'h17C
) (
    input  logic                  Bit_Rate,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic                  Data_Valid,
    output logic                  Data_Ready,
    output logic                  TX_Out,
    output logic                  Sym_Start,
    output logic                  Idle_Out,
    output logic                  Underflow
);

    localparam int unsigned      CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    // Kind of symbol currently in flight
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DATA = 1'b1;

    logic [DATA_WIDTH-1:0] sh_q,        sh_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [DATA_WIDTH-1:0] hold_q,      hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [0:0]            state_q,     state_d;
    logic                  rdy_en_q,    rdy_en_d;
    logic                  sym_start_q, sym_start_d;
    logic                  idle_out_q,  idle_out_d;
    logic                  underflow_q, underflow_d;

    logic boundary;
    logic accept;

    assign boundary   = (cnt_q == CNT_LAST);
    // Ready never looks at Data_Valid; at the boundary the buffer frees up on the same edge.
    assign Data_Ready = rdy_en_q & (~hold_full_q | boundary);
    assign accept     = Data_Valid & Data_Ready;

    assign TX_Out     = sh_q[0];
    assign Sym_Start  = sym_start_q;
    assign Idle_Out   = idle_out_q;
    assign Underflow  = underflow_q;

    // State registers; reset discards any in-flight or buffered symbol
    always_ff @(posedge Bit_Rate or negedge Rst) begin
        if (!Rst) begin
            sh_q        <= '0;
            cnt_q       <= CNT_LAST;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            state_q     <= ST_IDLE;
            rdy_en_q    <= 1'b0;
            sym_start_q <= 1'b0;
            idle_out_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            state_q     <= state_d;
            rdy_en_q    <= rdy_en_d;
            sym_start_q <= sym_start_d;
            idle_out_q  <= idle_out_d;
            underflow_q <= underflow_d;
        end
    end

    // Next-state: shift within a symbol, pick the next symbol at the boundary
    always_comb begin
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        state_d     = state_q;
        rdy_en_d    = 1'b1;
        sym_start_d = 1'b0;
        idle_out_d  = idle_out_q;
        underflow_d = 1'b0;

        if (!boundary) begin
            sh_d  = {1'b0, sh_q[DATA_WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (accept) begin
                hold_d      = Data_In;
                hold_full_d = 1'b1;
            end
        end else begin
            cnt_d       = '0;
            sym_start_d = 1'b1;
            if (hold_full_q) begin
                // Buffered symbol goes first; a same-cycle accept refills the buffer
                sh_d       = hold_q;
                state_d    = ST_DATA;
                idle_out_d = 1'b0;
                if (accept) begin
                    hold_d = Data_In;
                end else begin
                    hold_full_d = 1'b0;
                end
            end else if (accept) begin
                // Bypass: empty buffer, load straight into the shifter
                sh_d       = Data_In;
                state_d    = ST_DATA;
                idle_out_d = 1'b0;
            end else begin
                sh_d        = IDLE_SYMBOL;
                state_d     = ST_IDLE;
                idle_out_d  = 1'b1;
                underflow_d = (state_q == ST_DATA);
            end
        end
    end

endmodule

// File: tb/tb_tx_piso_serializer.sv
// Directed table-driven bench for tx_piso_serializer. Cycle k is the state seen
// 1ns after the k-th rising edge following reset release; inputs driven in cycle k
// are sampled at edge k+1. Each 10-cycle slot s spans cycles 10s+1 .. 10s+10.
module tb_tx_piso_serializer;

    localparam int unsigned DW   = 10;
    localparam int unsigned NCYC = 180;
    localparam logic [DW-1:0] IDLE_SYM = 10'h17C;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] data_in;
    logic          data_valid;
    logic          data_ready;
    logic          tx_out;
    logic          sym_start;
    logic          idle_out;
    logic          underflow;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic          tx;
        logic          rdy;
        logic          ss;
        logic          idle;
        logic          uf;
    } vec_t;

    vec_t vec [1:NCYC];

    tx_piso_serializer #(.DATA_WIDTH(DW), .IDLE_SYMBOL(IDLE_SYM)) dut (
        .Bit_Rate   (clk),
        .Rst        (rst_n),
        .Data_In    (data_in),
        .Data_Valid (data_valid),
        .Data_Ready (data_ready),
        .TX_Out     (tx_out),
        .Sym_Start  (sym_start),
        .Idle_Out   (idle_out),
        .Underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int cyc, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    // Expected line content for one 10-cycle slot
    task automatic slot(input int s, input logic [DW-1:0] sym, input logic idl, input logic uf);
        for (int b = 0; b < 10; b++) begin
            int k;
            k = 10 * s + 1 + b;
            vec[k].tx   = sym[b];
            vec[k].ss   = (b == 0);
            vec[k].idle = idl;
            vec[k].uf   = (b == 0) && uf;
        end
    endtask

    task automatic drive(input int k, input logic [DW-1:0] d);
        vec[k].valid = 1'b1;
        vec[k].data  = d;
    endtask

    task automatic not_ready(input int from, input int to);
        for (int k = from; k <= to; k++) vec[k].rdy = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] idle_v;
        idle_v = IDLE_SYM;

        // ---------------- build vector table ----------------
        for (int k = 1; k <= NCYC; k++) begin
            vec[k].valid = 1'b0;
            vec[k].data  = '0;
            vec[k].rdy   = 1'b1;
        end
        // idle stream
        slot(0, idle_v, 1'b1, 1'b0);
        slot(1, idle_v, 1'b1, 1'b0);
        slot(2, idle_v, 1'b1, 1'b0);
        slot(3, idle_v, 1'b1, 1'b0);
        // bypass at boundary cycle 40, then idle with underflow
        drive(40, 10'h2AA);
        slot(4, 10'h2AA, 1'b0, 1'b0);
        slot(5, idle_v, 1'b1, 1'b1);
        // back-to-back: 0F0 accepted mid-symbol, 3FF and 001 at boundaries
        drive(55, 10'h0F0);
        for (int k = 56; k <= 60; k++) drive(k, 10'h3FF);
        for (int k = 61; k <= 70; k++) drive(k, 10'h001);
        not_ready(56, 59);
        not_ready(61, 69);
        not_ready(71, 79);
        slot(6, 10'h0F0, 1'b0, 1'b0);
        slot(7, 10'h3FF, 1'b0, 1'b0);
        slot(8, 10'h001, 1'b0, 1'b0);
        slot(9, idle_v, 1'b1, 1'b1);
        // buffered accept at cnt==3 of an idle symbol
        slot(10, idle_v, 1'b1, 1'b0);
        drive(104, 10'h155);
        not_ready(105, 109);
        slot(11, 10'h155, 1'b0, 1'b0);
        slot(12, idle_v, 1'b1, 1'b1);
        // boundary collision: 0AA buffered, 355 accepted at the boundary
        slot(13, idle_v, 1'b1, 1'b0);
        drive(135, 10'h0AA);
        not_ready(136, 139);
        drive(140, 10'h355);
        not_ready(141, 149);
        slot(14, 10'h0AA, 1'b0, 1'b0);
        slot(15, 10'h355, 1'b0, 1'b0);
        slot(16, idle_v, 1'b1, 1'b1);
        slot(17, idle_v, 1'b1, 1'b0);

        // ---------------- reset ----------------
        rst_n      = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        repeat (3) step();
        chk("rst_tx",  0, tx_out,     1'b0);
        chk("rst_rdy", 0, data_ready, 1'b0);
        chk("rst_ss",  0, sym_start,  1'b0);
        chk("rst_idl", 0, idle_out,   1'b0);
        chk("rst_uf",  0, underflow,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy", 0, data_ready, 1'b0);

        // ---------------- table run ----------------
        for (int k = 1; k <= NCYC; k++) begin
            step();
            chk("tx",    k, tx_out,     vec[k].tx);
            chk("ready", k, data_ready, vec[k].rdy);
            chk("sym",   k, sym_start,  vec[k].ss);
            chk("idle",  k, idle_out,   vec[k].idle);
            chk("uflow", k, underflow,  vec[k].uf);
            data_valid = vec[k].valid;
            data_in    = vec[k].data;
        end

        // ---------------- reset mid-symbol with buffer full ----------------
        step();                              // cycle 181: idle symbol starts
        chk("mr_ss", 181, sym_start, 1'b1);
        data_valid = 1'b1;
        data_in    = 10'h3C3;
        step();                              // cycle 182: 3C3 now buffered
        chk("mr_full_rdy", 182, data_ready, 1'b0);
        data_valid = 1'b0;
        data_in    = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_tx",  182, tx_out,     1'b0);
        chk("mr_rdy", 182, data_ready, 1'b0);
        chk("mr_ss0", 182, sym_start,  1'b0);
        chk("mr_idl", 182, idle_out,   1'b0);
        chk("mr_uf",  182, underflow,  1'b0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mr_rel_rdy", 0, data_ready, 1'b0);
        // Buffered 3C3 must never appear: pure idle stream for two symbols
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("mr_tx",   k, tx_out,    idle_v[(k - 1) % 10]);
            chk("mr_sym",  k, sym_start, ((k - 1) % 10) == 0);
            chk("mr_idle", k, idle_out,  1'b1);
            chk("mr_uflow",k, underflow, 1'b0);
            chk("mr_ready",k, data_ready,1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_piso_serializer.md
# tx_piso_serializer

10-bit parallel-in/serial-out serializer for the SerDes TX path. It sits directly downstream of the `PLL` and runs on its `Bit_Rate` output. It takes encoded 10-bit symbols through a valid/ready handshake, holds one symbol in a single-entry buffer, and shifts symbols out LSB-first, one bit per `Bit_Rate` cycle. When no data is available it fills symbol slots with a comma/idle symbol, so the line never stalls.

## Interface
- `DATA_WIDTH`, 10, symbol width; the bit counter wraps at `DATA_WIDTH-1`.
- `IDLE_SYMBOL`, 10'h17C, K28.5 RD-; transmitted bit0 first: 0,0,1,1,1,1,1,0,1,0.

- `Bit_Rate`  in  1  serial bit clock from `PLL`; the only clock.
- `Rst`  in  1  asynchronous, active-low reset.
- `Data_In`  in  DATA_WIDTH  encoded symbol; bit0 is transmitted first.
- `Data_Valid`  in  1  `Data_In` is valid.
- `Data_Ready`  out  1  block accepts this cycle; accept = `Data_Valid & Data_Ready`.
- `TX_Out`  out  1  serial line bit.
- `Sym_Start`  out  1  high while `TX_Out` carries bit0 of a symbol.
- `Idle_Out`  out  1  high for all bits of an inserted idle symbol.
- `Underflow`  out  1  one-cycle pulse when an idle symbol follows a data symbol.

## Operation
- Internal state:
  - shift register `sh[9:0]`, with `TX_Out = sh[0]`;
  - bit counter `cnt` in 0..9;
  - holding buffer `buf` with flag `buf_full`;
  - 2-state FSM {IDLE, DATA} recording the kind of the symbol in flight;
  - `rdy_en` register, 0 in reset, set to 1 at the first edge after reset release.
- `Data_Ready = rdy_en & (!buf_full | cnt==9)`. This is combinational from registers and does not depend on `Data_Valid`.
- Each rising edge when `cnt != 9`:
  - `sh <= sh >> 1`; `cnt <= cnt+1`.
  - On accept: `buf <= Data_In`, `buf_full <= 1`.
- Each rising edge when `cnt == 9` (symbol boundary):
  - `cnt <= 0`.
  - Next symbol is chosen in priority order:
    1. `buf_full`: load `buf`.
    2. Accept this cycle with empty buffer: load `Data_In` directly (bypass).
    3. Otherwise: load `IDLE_SYMBOL`.
  - Buffer after the boundary:
    - Case 1 with accept: `buf <= Data_In`, stays full.
    - Case 1 without accept: `buf_full <= 0`.
    - Cases 2 and 3: buffer stays empty.
  - FSM: next state is DATA for cases 1–2 and IDLE for case 3.
  - `Underflow <= 1` iff current state is DATA and case 3 is taken; otherwise 0.
- `Sym_Start`, `Idle_Out` and `Underflow` are registered and aligned with the loaded symbol's bit0 on `TX_Out`.
- Symbol order is strictly the order of acceptance. No symbol is ever dropped or duplicated.

## Timing
- Reset (`Rst` low, asynchronous, takes effect immediately, including mid-symbol):
  - `sh`=0, `cnt`=9, buffer empty, FSM=IDLE, `rdy_en`=0.
  - Outputs: `TX_Out`=0, `Data_Ready`=0, `Sym_Start`=0, `Idle_Out`=0, `Underflow`=0.
  - Any buffered or in-flight symbol is discarded.
- First edge after release:
  - Loads `IDLE_SYMBOL` (`rdy_en` is still 0, so no accept is possible).
  - `Sym_Start`=`Idle_Out`=1 for that cycle.
- Throughput: one symbol per 10 `Bit_Rate` cycles. Under continuous `Data_Valid`, `Data_Ready` is high only in the `cnt==9` cycle once the buffer is full.
- Latency:
  - Bypass (accept at `cnt==9`, buffer empty): bit0 appears on `TX_Out` at the same edge.
  - Buffered: bit0 appears at the next boundary edge, within 1–9 cycles of acceptance.
- `Sym_Start` period is exactly 10 cycles after reset. `Idle_Out` stays constant for all 10 bits of a symbol.

## Test plan
- **Reset values.** Assert `Rst`=0 mid-symbol with the buffer full → all outputs 0 immediately. After release, with `Data_Valid`=0, the buffered symbol never appears.
- **Idle stream.** `Data_Valid`=0 for 40 cycles after reset → `TX_Out` repeats 0,0,1,1,1,1,1,0,1,0. `Sym_Start` is high at cycles 0, 10, 20, 30. `Idle_Out`=1 throughout. `Underflow` never pulses.
- **Single word, bypass.** Drive `Data_In`=10'h2AA valid only in a `cnt==9` cycle → next 10 bits are 0,1,0,1,0,1,0,1,0,1 with `Idle_Out`=0. The following symbol is idle, with one `Underflow` pulse at its bit0.
- **Back-to-back.** Accept 10'h0F0, then 10'h3FF, then 10'h001 with `Data_Valid` held → the three symbols are transmitted contiguously with no idle between them. `Data_Ready` is low while the buffer is full except at `cnt==9`.
- **Buffered mid-symbol accept.** Accept 10'h155 at `cnt==3` during idle → it is transmitted starting at the next boundary (6 cycles later). `Data_Ready`=0 from the next cycle until `cnt==9`.
- **Boundary collision.** Buffer full with 10'h0AA and a new accept of 10'h355 at `cnt==9` → 10'h0AA is transmitted next and 10'h355 immediately after it.
